// File: rtl/obj_tile_fetcher_if.sv
// Request, VRAM read port and pixel stream bundle for the OBJ tile fetcher.
// The fetcher uses the slave view. The requester, arbiter and pixel sink use the master view.
interface obj_tile_fetcher_if;
  // Span request
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_objname;
  logic [2:0]  req_bgmode;
  logic        req_palettemode;
  logic        req_oam_mode;
  logic [6:0]  req_hsize;
  logic [5:0]  req_x;
  logic [5:0]  req_y;
  logic [6:0]  req_len;
  // VRAM arbiter port
  logic        vram_re;
  logic [14:0] vram_addr;
  logic        vram_gnt;
  logic [15:0] vram_rdata;
  // Pixel stream
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_idx;
  logic [5:0]  pix_x;
  logic        pix_last;
  logic        done;

  modport master (
    output req_valid, req_objname, req_bgmode, req_palettemode, req_oam_mode,
           req_hsize, req_x, req_y, req_len, vram_gnt, vram_rdata, pix_ready,
    input  req_ready, vram_re, vram_addr, pix_valid, pix_idx, pix_x, pix_last, done
  );

  modport slave (
    input  req_valid, req_objname, req_bgmode, req_palettemode, req_oam_mode,
           req_hsize, req_x, req_y, req_len, vram_gnt, vram_rdata, pix_ready,
    output req_ready, vram_re, vram_addr, pix_valid, pix_idx, pix_x, pix_last, done
  );
endinterface

// File: rtl/obj_tile_fetcher.sv
// OBJ tile fetcher: maps sprite pixels to OBJ VRAM byte addresses, fetches
// halfwords through the arbiter, and streams 4bpp/8bpp palette indices.
module obj_tile_fetcher (
  input logic              clock,
  input logic              reset,
  obj_tile_fetcher_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StEmit} state_e;

  // Tile base address. Bit 5 is dropped for 2D 8bpp, where tiles occupy name pairs.
  function automatic logic [14:0] calc_base(input logic [9:0] objname,
                                            input logic [2:0] bgmode,
                                            input logic       pm,
                                            input logic       oam);
    return {objname[9] | (bgmode >= 3'd3), objname[8:1], objname[0] & (~pm | oam), 5'b0};
  endfunction

  // Row pitch shift: log2 of sprite width in 1D mode, fixed 128 bytes in 2D mode
  function automatic logic [2:0] calc_rs(input logic oam, input logic [6:0] hsize);
    logic [2:0] rs;
    rs = 3'd0;
    if (!oam) begin
      rs = 3'd7;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (hsize[i]) rs = 3'(i);
      end
    end
    return rs;
  endfunction

  function automatic logic [14:0] calc_xoff(input logic pm, input logic [5:0] x);
    return pm ? {9'b0, x} : {10'b0, x[5:1]};
  endfunction

  function automatic logic [7:0] extract(input logic [15:0] hw, input logic a0,
                                         input logic pm, input logic x0);
    logic [7:0] b;
    b = a0 ? hw[15:8] : hw[7:0];
    return pm ? b : {4'b0, (x0 ? b[7:4] : b[3:0])};
  endfunction

  state_e      state_q, state_d;
  logic [14:0] row_q, row_d;         // base + row offset of the active span
  logic        pm_q, pm_d;
  logic [5:0]  x_q, x_d;
  logic [6:0]  rem_q, rem_d;
  logic [14:0] addr_q, addr_d;       // byte address of the current pixel
  logic [15:0] buf_q, buf_d;
  logic [13:0] tag_q, tag_d;
  logic        bvalid_q, bvalid_d;
  logic        req_ready_q, req_ready_d;
  logic        vram_re_q, vram_re_d;
  logic [14:0] vram_addr_q, vram_addr_d;
  logic        pix_valid_q, pix_valid_d;
  logic [7:0]  pix_idx_q, pix_idx_d;
  logic [5:0]  pix_x_q, pix_x_d;
  logic        pix_last_q, pix_last_d;
  logic        done_q, done_d;

  logic [14:0] req_row, req_addr, addr_nxt;
  logic [5:0]  x_nxt;
  logic [6:0]  rem_nxt;

  assign req_row  = calc_base(bus.req_objname, bus.req_bgmode, bus.req_palettemode,
                              bus.req_oam_mode)
                  + ({9'b0, bus.req_y} << calc_rs(bus.req_oam_mode, bus.req_hsize));
  assign req_addr = req_row + calc_xoff(bus.req_palettemode, bus.req_x);
  assign x_nxt    = x_q + 6'd1;
  assign addr_nxt = row_q + calc_xoff(pm_q, x_nxt);
  assign rem_nxt  = rem_q - 7'd1;

  // Next-state and registered-output logic for the span FSM
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pm_d        = pm_q;
    x_d         = x_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    tag_d       = tag_q;
    bvalid_d    = bvalid_q;
    req_ready_d = req_ready_q;
    vram_re_d   = vram_re_q;
    vram_addr_d = vram_addr_q;
    pix_valid_d = pix_valid_q;
    pix_idx_d   = pix_idx_q;
    pix_x_d     = pix_x_q;
    pix_last_d  = pix_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          row_d    = req_row;
          pm_d     = bus.req_palettemode;
          x_d      = bus.req_x;
          rem_d    = bus.req_len;
          addr_d   = req_addr;
          bvalid_d = 1'b0;
          if (bus.req_len == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StFetch;
            req_ready_d = 1'b0;
            vram_re_d   = 1'b1;
            vram_addr_d = req_addr;
          end
        end
      end
      StFetch: begin
        if (bus.vram_gnt) begin
          state_d   = StWait;
          vram_re_d = 1'b0;
        end
      end
      StWait: begin
        buf_d       = bus.vram_rdata;
        tag_d       = addr_q[14:1];
        bvalid_d    = 1'b1;
        state_d     = StEmit;
        pix_valid_d = 1'b1;
        pix_idx_d   = extract(bus.vram_rdata, addr_q[0], pm_q, x_q[0]);
        pix_x_d     = x_q;
        pix_last_d  = (rem_q == 7'd1);
      end
      StEmit: begin
        if (bus.pix_ready) begin
          x_d    = x_nxt;
          rem_d  = rem_nxt;
          addr_d = addr_nxt;
          if (rem_q == 7'd1) begin
            state_d     = StIdle;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            req_ready_d = 1'b1;
            done_d      = 1'b1;
          end else if (bvalid_q && (addr_nxt[14:1] == tag_q)) begin
            pix_idx_d  = extract(buf_q, addr_nxt[0], pm_q, x_nxt[0]);
            pix_x_d    = x_nxt;
            pix_last_d = (rem_nxt == 7'd1);
          end else begin
            state_d     = StFetch;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            vram_re_d   = 1'b1;
            vram_addr_d = addr_nxt;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      pm_q        <= 1'b0;
      x_q         <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      tag_q       <= '0;
      bvalid_q    <= 1'b0;
      req_ready_q <= 1'b1;
      vram_re_q   <= 1'b0;
      vram_addr_q <= '0;
      pix_valid_q <= 1'b0;
      pix_idx_q   <= '0;
      pix_x_q     <= '0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pm_q        <= pm_d;
      x_q         <= x_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      tag_q       <= tag_d;
      bvalid_q    <= bvalid_d;
      req_ready_q <= req_ready_d;
      vram_re_q   <= vram_re_d;
      vram_addr_q <= vram_addr_d;
      pix_valid_q <= pix_valid_d;
      pix_idx_q   <= pix_idx_d;
      pix_x_q     <= pix_x_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.vram_re   = vram_re_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_idx   = pix_idx_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_obj_tile_fetcher.sv
// Directed bench for obj_tile_fetcher with a one-cycle-latency VRAM model.
module tb_obj_tile_fetcher;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  obj_tile_fetcher_if vif ();

  obj_tile_fetcher dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif)
  );

  logic [15:0] mem [0:16383];
  logic [14:0] rd_log [0:63];
  int          reads = 0;

  // VRAM model: data one cycle after acceptance, junk otherwise
  always @(posedge clock) begin
    vif.vram_rdata <= 16'hDEAD;
    if (vif.vram_re && vif.vram_gnt) begin
      vif.vram_rdata     <= mem[vif.vram_addr[14:1]];
      rd_log[reads[5:0]] <= vif.vram_addr;
      reads              <= reads + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  int last_wait = 0;
  int r0 = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, 32'(vif.req_ready), 1);
    chk({tag, ".vram_re"}, 32'(vif.vram_re), 0);
    chk({tag, ".vram_addr"}, 32'(vif.vram_addr), 0);
    chk({tag, ".pix_valid"}, 32'(vif.pix_valid), 0);
    chk({tag, ".pix_idx"}, 32'(vif.pix_idx), 0);
    chk({tag, ".pix_x"}, 32'(vif.pix_x), 0);
    chk({tag, ".pix_last"}, 32'(vif.pix_last), 0);
    chk({tag, ".done"}, 32'(vif.done), 0);
  endtask

  // Present one request for one cycle; returns in the cycle after acceptance
  task automatic send_req(input logic [9:0] name, input logic [2:0] bg, input logic pm,
                          input logic oam, input logic [6:0] hs, input logic [5:0] x,
                          input logic [5:0] y, input logic [6:0] len);
    vif.req_objname     = name;
    vif.req_bgmode      = bg;
    vif.req_palettemode = pm;
    vif.req_oam_mode    = oam;
    vif.req_hsize       = hs;
    vif.req_x           = x;
    vif.req_y           = y;
    vif.req_len         = len;
    vif.req_valid       = 1'b1;
    tick();
    vif.req_valid = 1'b0;
  endtask

  // Wait (bounded) for a pixel, check it and the cycles waited, then consume it
  task automatic take_pix(input string tag, input logic [7:0] idx, input logic [5:0] x,
                          input logic last, input int exp_wait);
    last_wait = 0;
    while (!vif.pix_valid && last_wait < 20) begin
      tick();
      last_wait++;
    end
    chk({tag, ".valid"}, 32'(vif.pix_valid), 1);
    chk({tag, ".wait"}, 32'(last_wait), 32'(exp_wait));
    chk({tag, ".idx"}, 32'(vif.pix_idx), 32'(idx));
    chk({tag, ".x"}, 32'(vif.pix_x), 32'(x));
    chk({tag, ".last"}, 32'(vif.pix_last), 32'(last));
    tick();
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"}, 32'(vif.done), 1);
    chk({tag, ".req_ready"}, 32'(vif.req_ready), 1);
    chk({tag, ".pix_valid"}, 32'(vif.pix_valid), 0);
    tick();
    chk({tag, ".done_drop"}, 32'(vif.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vif.req_valid       = 1'b0;
    vif.req_objname     = '0;
    vif.req_bgmode      = '0;
    vif.req_palettemode = 1'b0;
    vif.req_oam_mode    = 1'b0;
    vif.req_hsize       = '0;
    vif.req_x           = '0;
    vif.req_y           = '0;
    vif.req_len         = '0;
    vif.vram_gnt        = 1'b1;
    vif.pix_ready       = 1'b1;
    mem[176]  = 16'h4321;
    mem[225]  = 16'hAB00;
    mem[226]  = 16'h2211;
    mem[227]  = 16'h7766;
    mem[31]   = 16'hBBAA;
    mem[0]    = 16'hDDCC;
    mem[8192] = 16'h00EE;

    repeat (2) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // 4bpp 1D: single read at 352, pixels 1..4 on cycles 3..6
    r0 = reads;
    send_req(10'd10, 3'd0, 1'b0, 1'b1, 7'd16, 6'd0, 6'd2, 7'd4);
    chk("t1.re", 32'(vif.vram_re), 1);
    chk("t1.addr", 32'(vif.vram_addr), 352);
    chk("t1.req_ready", 32'(vif.req_ready), 0);
    take_pix("t1p0", 8'd1, 6'd0, 1'b0, 2);
    take_pix("t1p1", 8'd2, 6'd1, 1'b0, 0);
    take_pix("t1p2", 8'd3, 6'd2, 1'b0, 0);
    take_pix("t1p3", 8'd4, 6'd3, 1'b1, 0);
    chk_done("t1");
    chk("t1.reads", 32'(reads - r0), 1);
    chk("t1.rd0", 32'(rd_log[6'(r0)]), 352);

    // 8bpp 2D: reads at 451 and 452, miss costs two bubbles
    r0 = reads;
    send_req(10'd11, 3'd0, 1'b1, 1'b0, 7'd0, 6'd3, 6'd1, 7'd3);
    take_pix("t2p0", 8'hAB, 6'd3, 1'b0, 2);
    chk("t2.re", 32'(vif.vram_re), 1);
    chk("t2.addr", 32'(vif.vram_addr), 452);
    take_pix("t2p1", 8'h11, 6'd4, 1'b0, 2);
    take_pix("t2p2", 8'h22, 6'd5, 1'b1, 0);
    chk_done("t2");
    chk("t2.reads", 32'(reads - r0), 2);
    chk("t2.rd0", 32'(rd_log[6'(r0)]), 451);
    chk("t2.rd1", 32'(rd_log[6'(r0 + 1)]), 452);

    // Grant stall for 3 cycles, then pixel backpressure for 2 cycles
    r0 = reads;
    vif.vram_gnt = 1'b0;
    send_req(10'd10, 3'd0, 1'b0, 1'b1, 7'd16, 6'd0, 6'd2, 7'd4);
    for (int i = 0; i < 3; i++) begin
      chk("t3.stall_re", 32'(vif.vram_re), 1);
      chk("t3.stall_addr", 32'(vif.vram_addr), 352);
      tick();
    end
    vif.vram_gnt = 1'b1;
    chk("t3.re_gnt", 32'(vif.vram_re), 1);
    take_pix("t3p0", 8'd1, 6'd0, 1'b0, 2);
    vif.pix_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t3.bp_valid", 32'(vif.pix_valid), 1);
      chk("t3.bp_idx", 32'(vif.pix_idx), 2);
      chk("t3.bp_x", 32'(vif.pix_x), 1);
      chk("t3.bp_last", 32'(vif.pix_last), 0);
      tick();
    end
    vif.pix_ready = 1'b1;
    take_pix("t3p1", 8'd2, 6'd1, 1'b0, 0);
    take_pix("t3p2", 8'd3, 6'd2, 1'b0, 0);
    take_pix("t3p3", 8'd4, 6'd3, 1'b1, 0);
    chk_done("t3");
    chk("t3.reads", 32'(reads - r0), 1);

    // Column wrap 63 -> 0 re-fetches at the row start
    r0 = reads;
    send_req(10'd0, 3'd0, 1'b1, 1'b0, 7'd0, 6'd62, 6'd0, 7'd4);
    take_pix("t4p0", 8'hAA, 6'd62, 1'b0, 2);
    take_pix("t4p1", 8'hBB, 6'd63, 1'b0, 0);
    take_pix("t4p2", 8'hCC, 6'd0, 1'b0, 2);
    take_pix("t4p3", 8'hDD, 6'd1, 1'b1, 0);
    chk_done("t4");
    chk("t4.reads", 32'(reads - r0), 2);
    chk("t4.rd0", 32'(rd_log[6'(r0)]), 62);
    chk("t4.rd1", 32'(rd_log[6'(r0 + 1)]), 0);

    // Empty span: done next cycle, no read
    r0 = reads;
    send_req(10'd10, 3'd0, 1'b0, 1'b1, 7'd16, 6'd0, 6'd2, 7'd0);
    chk("t5.re", 32'(vif.vram_re), 0);
    chk_done("t5");
    chk("t5.re_after", 32'(vif.vram_re), 0);
    chk("t5.reads", 32'(reads - r0), 0);

    // Reset during the fetch after the 2nd pixel; returned data must be ignored
    send_req(10'd11, 3'd0, 1'b1, 1'b0, 7'd0, 6'd4, 6'd1, 7'd4);
    take_pix("t6p0", 8'h11, 6'd4, 1'b0, 2);
    take_pix("t6p1", 8'h22, 6'd5, 1'b0, 0);
    chk("t6.re", 32'(vif.vram_re), 1);
    chk("t6.addr", 32'(vif.vram_addr), 454);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("t6rst");
    tick();
    chk("t6.post_valid", 32'(vif.pix_valid), 0);
    chk("t6.post_re", 32'(vif.vram_re), 0);
    chk("t6.post_done", 32'(vif.done), 0);
    chk("t6.post_ready", 32'(vif.req_ready), 1);
    send_req(10'd10, 3'd0, 1'b0, 1'b1, 7'd16, 6'd0, 6'd2, 7'd4);
    chk("t6n.addr", 32'(vif.vram_addr), 352);
    take_pix("t6n0", 8'd1, 6'd0, 1'b0, 2);
    take_pix("t6n1", 8'd2, 6'd1, 1'b0, 0);
    take_pix("t6n2", 8'd3, 6'd2, 1'b0, 0);
    take_pix("t6n3", 8'd4, 6'd3, 1'b1, 0);
    chk_done("t6n");

    // bgmode 3 forces address bit 14
    send_req(10'd0, 3'd3, 1'b1, 1'b1, 7'd8, 6'd0, 6'd0, 7'd1);
    chk("t7.re", 32'(vif.vram_re), 1);
    chk("t7.addr", 32'(vif.vram_addr), 16384);
    take_pix("t7p0", 8'hEE, 6'd0, 1'b1, 2);
    chk_done("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obj_tile_fetcher.md
# obj_tile_fetcher

Reads OBJ (sprite) tile pixels out of OBJ VRAM for the sprite renderer. Accepts one span request (sprite tile/row parameters, start column, pixel count). Computes the VRAM byte address of each pixel and issues halfword reads through the VRAM arbiter port. Unpacks 4bpp or 8bpp palette indices and streams them out one per cycle under ready/valid backpressure. It is the consumer of the OBJ VRAM address mapping: it owns both the address generation and the read side of the same layout.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  span request valid
- req_ready  out  1  high only in IDLE
- req_objname  in  10  tile name
- req_bgmode  in  3  current BG mode
- req_palettemode  in  1  1 = 8bpp (256-colour), 0 = 4bpp
- req_oam_mode  in  1  1 = 1D mapping, 0 = 2D mapping
- req_hsize  in  7  sprite width in pixels (1D row pitch)
- req_x  in  6  start column within sprite
- req_y  in  6  row within sprite
- req_len  in  7  pixel count, 0..64
- vram_re  out  1  read request
- vram_addr  out  15  byte address; the memory uses [14:1]
- vram_gnt  in  1  arbiter grant; a read is accepted when vram_re & vram_gnt
- vram_rdata  in  16  halfword, valid exactly 1 cycle after acceptance
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_idx  out  8  palette index; 4bpp is zero-extended
- pix_x  out  6  column of this pixel
- pix_last  out  1  final pixel of the span
- done  out  1  one-cycle pulse when the span completes

## Operation
- Request fields are latched on req_valid & req_ready.
- Address = base + xoff + (y << rs), computed mod 2^15.
  - base = {objname[9] | (bgmode >= 3), objname[8:1], objname[0] & (~palettemode | oam_mode), 5'b0}.
  - xoff = palettemode ? x : x >> 1.
  - rs = oam_mode ? index of the highest set bit of hsize (0 if hsize == 0) : 7.
- Pixel extraction:
  - byte = addr[0] ? rdata[15:8] : rdata[7:0].
  - 8bpp: idx = byte.
  - 4bpp: idx = {4'b0, x[0] ? byte[7:4] : byte[3:0]}.
- Current column x starts at req_x and increments by 1 per emitted pixel, wrapping modulo 64 (63 → 0).
- Halfword buffer:
  - Holds the last fetched halfword and its tag addr[14:1].
  - The next pixel reuses the buffer if its tag matches; otherwise a new fetch is issued.
  - The buffer is invalidated on each new request.
- FSM states: IDLE, FETCH, WAIT, EMIT.
  - IDLE: req_ready=1. On accept: if req_len == 0 → pulse done next cycle and stay in IDLE; else → FETCH.
  - FETCH: vram_re=1 with the current pixel's address. On vram_gnt → WAIT. Without gnt, hold and keep vram_addr stable.
  - WAIT: latch vram_rdata and tag → EMIT.
  - EMIT: pix_valid=1. On pix_ready: advance x and decrement remaining.
    - If remaining becomes 0 → IDLE, with done pulsed in the IDLE entry cycle.
    - Else if the next pixel's tag differs → FETCH.
    - Else stay in EMIT.
- pix_last = pix_valid & (remaining == 1).
- Reset at any point: state IDLE, buffer invalid, all outputs at reset values. An in-flight read's returning data is ignored.

## Timing
- Reset values: req_ready=1; vram_re=0; vram_addr=0; pix_valid=0; pix_idx=0; pix_x=0; pix_last=0; done=0.
- Accept at cycle 0. vram_re in cycle 1; gnt in cycle 1 → data latched end of cycle 2 → first pix_valid in cycle 3. Each missing gnt cycle adds 1.
- Buffer hits emit back-to-back, one pixel per cycle while pix_ready=1.
- A miss costs 2 bubble cycles (FETCH + WAIT) with gnt immediate.
- While pix_valid=1 and pix_ready=0, pix_idx, pix_x and pix_last hold stable.
- done is asserted for exactly 1 cycle, the cycle after the last handshake; req_ready is already 1 in that cycle.
- req_valid outside IDLE is ignored, not queued.

## Test plan
- 4bpp, 1D: objname=10, hsize=16, x=0, y=2, len=4, gnt=1, rdata=0x4321 → one read at vram_addr=352 → pix_idx 1,2,3,4 at x 0..3 on cycles 3..6; pix_last on x=3; done on cycle 7.
- 8bpp, 2D: objname=11, x=3, y=1, len=3, reads return 0xAB00 then 0x2211 → reads at 451 then 452; pixels 0xAB, 0x11, 0x22.
- Backpressure and grant stall: hold vram_gnt=0 for 3 cycles → vram_re/vram_addr stable, first pixel delayed 3 cycles. Hold pix_ready=0 for 2 cycles mid-span → pix_idx, pix_x, pix_last held stable, no pixel lost or duplicated.
- Wrap and empty:
  - x=62, 8bpp, len=4 → pix_x 62,63,0,1, with x=0 re-fetched at the new address.
  - len=0 → no vram_re, done pulses 1 cycle after accept.
- Reset mid-span after the 2nd pixel → next cycle all outputs at reset values, rdata returned afterwards ignored. A new request then runs cleanly.
- bgmode=3 with objname[9]=0 → vram_addr bit14=1.
